// File: rtl/alb_mss_mem_ibp_rsp_buf_pkg.sv
// Shared constants for the IBP response buffer.
// Covers the default data width, the FIFO entry widths and the bit positions of each entry field.
package alb_mss_mem_ibp_rsp_buf_pkg;

  localparam int D_W = 32;

  // Read entry layout, LSB first: excl_ok, err_rd, last, data.
  localparam int RD_EXCL_BIT = 0;
  localparam int RD_ERR_BIT  = 1;
  localparam int RD_LAST_BIT = 2;
  localparam int RD_DATA_LSB = 3;
  localparam int RD_ENT_W    = D_W + RD_DATA_LSB;

  // Write-response entry layout: {excl_done, err_wr}.
  localparam int WR_ERR_BIT  = 0;
  localparam int WR_EXCL_BIT = 1;
  localparam int WR_ENT_W    = 2;

endpackage

// File: rtl/alb_mss_mem_rsp_fifo.sv
// Small valid/accept FIFO with wrap-bit pointers and no bypass path.
// The head data reads as zero while the FIFO is empty.
module alb_mss_mem_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_accept,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_accept,
  output logic [WIDTH-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign in_accept = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = out_accept && !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are masked until pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

endmodule

// File: rtl/alb_mss_mem_ibp_rsp_buf.sv
// Registered IBP read-data and write-response path (target to initiator).
// Tracks outstanding commands so that unsolicited responses are refused and flagged.
module alb_mss_mem_ibp_rsp_buf
  import alb_mss_mem_ibp_rsp_buf_pkg::*;
#(
  parameter int d_w       = D_W,
  parameter int BUF_DEPTH = 2,
  parameter int OUTST_W   = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  input  logic           mon_cmd_valid,
  input  logic           mon_cmd_accept,
  input  logic           mon_cmd_read,
  input  logic           o_ibp_rd_valid,
  output logic           o_ibp_rd_accept,
  input  logic [d_w-1:0] o_ibp_rd_data,
  input  logic           o_ibp_rd_last,
  input  logic           o_ibp_err_rd,
  input  logic           o_ibp_rd_excl_ok,
  input  logic           o_ibp_wr_done,
  input  logic           o_ibp_wr_excl_done,
  input  logic           o_ibp_err_wr,
  output logic           o_ibp_wr_resp_accept,
  output logic           i_ibp_rd_valid,
  input  logic           i_ibp_rd_accept,
  output logic [d_w-1:0] i_ibp_rd_data,
  output logic           i_ibp_rd_last,
  output logic           i_ibp_err_rd,
  output logic           i_ibp_rd_excl_ok,
  output logic           i_ibp_wr_done,
  output logic           i_ibp_wr_excl_done,
  output logic           i_ibp_err_wr,
  input  logic           i_ibp_wr_resp_accept,
  output logic           outst_full,
  output logic           proto_err
);

  localparam int RD_W = d_w + RD_ENT_W - D_W;
  localparam logic [OUTST_W-1:0] CNT_MAX = {OUTST_W{1'b1}};

  logic [OUTST_W-1:0] rd_cnt, rd_cnt_nxt;
  logic [OUTST_W-1:0] wr_cnt, wr_cnt_nxt;
  logic rd_cmd, wr_cmd, rd_ovf, wr_ovf;
  logic rd_not_full, wr_not_full;
  logic rd_push, wr_push, rd_dec;
  logic rd_unsol, wr_unsol;
  logic [RD_W-1:0]     rd_in, rd_out;
  logic [WR_ENT_W-1:0] wr_in, wr_out;

  assign rd_cmd = mon_cmd_valid && mon_cmd_accept && mon_cmd_read;
  assign wr_cmd = mon_cmd_valid && mon_cmd_accept && !mon_cmd_read;

  // A response is only taken when its command is outstanding or passing right now.
  assign o_ibp_rd_accept      = rd_not_full && ((rd_cnt != '0) || rd_cmd);
  assign o_ibp_wr_resp_accept = wr_not_full && ((wr_cnt != '0) || wr_cmd);

  assign rd_push = o_ibp_rd_valid && o_ibp_rd_accept;
  assign wr_push = o_ibp_wr_done && o_ibp_wr_resp_accept;
  assign rd_dec  = rd_push && o_ibp_rd_last;

  assign rd_in = {o_ibp_rd_data, o_ibp_rd_last, o_ibp_err_rd, o_ibp_rd_excl_ok};
  assign wr_in = {o_ibp_wr_excl_done, o_ibp_err_wr};

  alb_mss_mem_rsp_fifo #(.WIDTH(RD_W), .DEPTH(BUF_DEPTH)) u_rd_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .in_valid   (rd_push),
    .in_accept  (rd_not_full),
    .in_data    (rd_in),
    .out_valid  (i_ibp_rd_valid),
    .out_accept (i_ibp_rd_accept),
    .out_data   (rd_out)
  );

  alb_mss_mem_rsp_fifo #(.WIDTH(WR_ENT_W), .DEPTH(BUF_DEPTH)) u_wr_fifo (
    .clk        (clk),
    .rst_b      (rst_b),
    .in_valid   (wr_push),
    .in_accept  (wr_not_full),
    .in_data    (wr_in),
    .out_valid  (i_ibp_wr_done),
    .out_accept (i_ibp_wr_resp_accept),
    .out_data   (wr_out)
  );

  assign i_ibp_rd_data      = rd_out[RD_W-1:RD_DATA_LSB];
  assign i_ibp_rd_last      = rd_out[RD_LAST_BIT];
  assign i_ibp_err_rd       = rd_out[RD_ERR_BIT];
  assign i_ibp_rd_excl_ok   = rd_out[RD_EXCL_BIT];
  assign i_ibp_wr_excl_done = wr_out[WR_EXCL_BIT];
  assign i_ibp_err_wr       = wr_out[WR_ERR_BIT];

  always_comb begin
    rd_cnt_nxt = rd_cnt;
    wr_cnt_nxt = wr_cnt;
    rd_ovf     = 1'b0;
    wr_ovf     = 1'b0;
    if (rd_cmd && !rd_dec) begin
      if (rd_cnt == CNT_MAX) rd_ovf = 1'b1;
      else                   rd_cnt_nxt = rd_cnt + 1'b1;
    end else if (!rd_cmd && rd_dec) begin
      rd_cnt_nxt = rd_cnt - 1'b1;
    end
    if (wr_cmd && !wr_push) begin
      if (wr_cnt == CNT_MAX) wr_ovf = 1'b1;
      else                   wr_cnt_nxt = wr_cnt + 1'b1;
    end else if (!wr_cmd && wr_push) begin
      wr_cnt_nxt = wr_cnt - 1'b1;
    end
  end

  assign rd_unsol   = o_ibp_rd_valid && (rd_cnt == '0) && !rd_cmd;
  assign wr_unsol   = o_ibp_wr_done && (wr_cnt == '0) && !wr_cmd;
  assign outst_full = (rd_cnt == CNT_MAX) || (wr_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      proto_err <= 1'b0;
    end else begin
      rd_cnt <= rd_cnt_nxt;
      wr_cnt <= wr_cnt_nxt;
      if (rd_unsol || wr_unsol || rd_ovf || wr_ovf) proto_err <= 1'b1;
    end
  end

endmodule
